result_display_scanner: RTL

Downstream display stage for the BNN OCR system. It captures each classification result from the BNN interface on the rising edge of `result_ready` and keeps a 4-deep history of recent results. It time-multiplexes that history onto a 4-digit common-anode 7-segment display, driving all segments and anodes active-low. It also flashes the decimal point on the newest digit after each capture and counts results.

---
 rtl/result_display_scanner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/result_display_scanner.sv
// rtl/result_display_scanner.sv - captures BNN results into a short history and scans them onto a 4-digit 7-segment display
// Optional feature macro: STATUS_DIGIT_EN (digit 3 shows status_code, history depth 3)

module result_display_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int FLASH_LEN   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] result_in,
    input  logic       result_ready,
    input  logic       clear,
    input  logic [3:0] status_code,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic [7:0] result_count
);

`ifdef STATUS_DIGIT_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 4;
`endif
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(FLASH_LEN + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Decimal digit patterns; anything above 9 is shown as a dash
    function automatic logic [6:0] dec_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

`ifdef STATUS_DIGIT_EN
    // Full hexadecimal patterns for the status digit
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = dec_seg(v);
        endcase
        return s;
    endfunction
`else
    logic unused_status;
    assign unused_status = ^status_code;
`endif

    logic                        rdy_q,   rdy_d;
    logic [DEPTH-1:0][3:0]       hval_q,  hval_d;
    logic [DEPTH-1:0]            hvld_q,  hvld_d;
    logic [7:0]                  cnt_q,   cnt_d;
    logic [FW-1:0]               flash_q, flash_d;
    logic [RW-1:0]               ref_q,   ref_d;
    logic [1:0]                  sel_q,   sel_d;
    logic [6:0]                  seg_q,   seg_d;
    logic [3:0]                  an_q,    an_d;
    logic                        dp_q,    dp_d;
    logic                        capture;
    logic [3:0]                  cur_val;
    logic                        cur_vld;

    // Result capture, history shift, counter and flash timer; clear overrides capture
    always_comb begin
        capture = result_ready && !rdy_q;
        rdy_d   = result_ready;
        hval_d  = hval_q;
        hvld_d  = hvld_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
        if (clear) begin
            hvld_d  = '0;
            cnt_d   = 8'd0;
            flash_d = '0;
        end else if (capture) begin
            hval_d  = {hval_q[DEPTH-2:0], result_in};
            hvld_d  = {hvld_q[DEPTH-2:0], 1'b1};
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
            flash_d = FLASH_LEN[FW-1:0];
        end else if (flash_q != '0) begin
            flash_d = flash_q - 1'b1;
        end
    end

    // Refresh divider and digit selector
    always_comb begin
        ref_d = ref_q + 1'b1;
        sel_d = sel_q;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            sel_d = sel_q + 2'd1;
        end
    end

    // Decode the selected digit into next segment, anode and dp values
    always_comb begin
        cur_val = 4'h0;
        cur_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_q == 2'(i)) begin
                cur_val = hval_q[i];
                cur_vld = hvld_q[i];
            end
        end
`ifdef STATUS_DIGIT_EN
        if (sel_q == 2'd3) begin
            seg_d = hex_seg(status_code);
        end else begin
            seg_d = cur_vld ? dec_seg(cur_val) : SEG_BLANK;
        end
`else
        seg_d = cur_vld ? dec_seg(cur_val) : SEG_BLANK;
`endif
        an_d = ~(4'b0001 << sel_q);
        dp_d = !((sel_q == 2'd0) && (flash_q != '0) && hvld_q[0]);
    end

    // State and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q   <= 1'b1;
            hval_q  <= '0;
            hvld_q  <= '0;
            cnt_q   <= 8'd0;
            flash_q <= '0;
            ref_q   <= '0;
            sel_q   <= 2'd0;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
        end else begin
            rdy_q   <= rdy_d;
            hval_q  <= hval_d;
            hvld_q  <= hvld_d;
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
            ref_q   <= ref_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg          = seg_q;
    assign an           = an_q;
    assign dp           = dp_q;
    assign result_count = cnt_q;

endmodule
